// File: rtl/nixie_fade_driver.sv
// nixie_fade_driver
//   Nixie-tube cathode driver. Patterns arrive over a serial shift interface
//   and are double-buffered behind a latch strobe. A global PWM brightness gate
//   is applied to the cathode outputs, and the block also generates the
//   neon-separator square wave.
//
//   Optional feature macro: NIXIE_FADE_EN
//     defined   : on latch, a timed crossfade runs from the previous pattern
//                 to the new one (PWM-slot based dither between prev and cur).
//     undefined : latch loads cur only, fade_busy is tied 0.
//
// Ports
//   clk        in   system clock, all logic rising-edge
//   rst        in   asynchronous active-high reset
//   sdata      in   serial pattern bit
//   shift_en   in   shift sdata into the shift register this cycle
//   latch      in   single-cycle strobe: shift register -> display
//   en         in   output enable (also gates the neon drive)
//   brightness in   global PWM duty, on when pwm_cnt < brightness
//   out        out  cathode drive, registered, W = NUM_TUBES*SEGS_PER_TUBE
//   neon_pwm   out  neon separator square wave, period 2*NEON_DIV cycles
//   fade_busy  out  crossfade in progress
module nixie_fade_driver #(
  parameter int NUM_TUBES     = 6,
  parameter int SEGS_PER_TUBE = 12,
  parameter int PWM_BITS      = 8,
  parameter int FADE_DIV      = 1,
  parameter int NEON_DIV      = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sdata,
  input  logic                                 shift_en,
  input  logic                                 latch,
  input  logic                                 en,
  input  logic [PWM_BITS-1:0]                  brightness,
  output logic [NUM_TUBES*SEGS_PER_TUBE-1:0]   out,
  output logic                                 neon_pwm,
  output logic                                 fade_busy
);

  localparam int W  = NUM_TUBES * SEGS_PER_TUBE;
  localparam int NW = (NEON_DIV > 1) ? $clog2(NEON_DIV) : 1;
  localparam logic [NW-1:0] NEON_LAST = NW'(NEON_DIV - 1);

  if (FADE_DIV < 1 || NEON_DIV < 1) begin : g_bad_param
    $error("nixie_fade_driver: FADE_DIV and NEON_DIV must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Shift register, display register, PWM counter
  // ---------------------------------------------------------------------------
  logic [W-1:0]          sr_q, sr_d;
  logic [W-1:0]          cur_q, cur_d;
  logic [W-1:0]          out_q, out_d;
  logic [W-1:0]          pat;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  on;

  always_comb begin
    sr_d      = sr_q;
    cur_d     = cur_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;   // free-running, wraps naturally
    // cur takes the pre-shift contents when latch and shift_en coincide
    if (latch)    cur_d = sr_q;
    if (shift_en) sr_d  = {sr_q[W-2:0], sdata};
  end

  assign on = (pwm_cnt_q < brightness);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      cur_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      cur_q     <= cur_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef NIXIE_FADE_EN
  // ---------------------------------------------------------------------------
  // Crossfade: fade_pos counts PWM slots that already show the new pattern.
  // It advances by one every FADE_DIV PWM periods, so the new pattern takes
  // over one slot at a time; reaching 2^PWM_BITS means fully faded.
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, FADING} state_t;

  localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DW-1:0]       DIV_LAST  = DW'(FADE_DIV - 1);
  localparam logic [PWM_BITS:0]   FADE_FULL = {1'b1, {PWM_BITS{1'b0}}};

  state_t              state_q, state_d;
  logic [W-1:0]        prev_q, prev_d;
  logic [PWM_BITS:0]   fade_pos_q, fade_pos_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic                pwm_wrap;

  assign pwm_wrap = &pwm_cnt_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    fade_pos_d = fade_pos_q;
    div_cnt_d  = div_cnt_q;
    if (latch) begin
      // a latch mid-fade restarts from the new target, not from the blend
      prev_d     = cur_q;
      fade_pos_d = '0;
      div_cnt_d  = '0;
      state_d    = FADING;
    end else begin
      case (state_q)
        FADING: begin
          if (pwm_wrap) begin
            if (div_cnt_q == DIV_LAST) begin
              div_cnt_d  = '0;
              fade_pos_d = fade_pos_q + 1'b1;
              if (fade_pos_d == FADE_FULL) state_d = IDLE;
            end else begin
              div_cnt_d = div_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      fade_pos_q <= FADE_FULL;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      fade_pos_q <= fade_pos_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  assign pat       = ({1'b0, pwm_cnt_q} < fade_pos_q) ? cur_q : prev_q;
  assign fade_busy = (state_q == FADING);
`else
  assign pat       = cur_q;
  assign fade_busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d = (en && on) ? pat : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

  // ---------------------------------------------------------------------------
  // Neon separator: toggles every NEON_DIV enabled cycles. Held at phase 0
  // while disabled so re-enabling always starts a fresh low half-period.
  // ---------------------------------------------------------------------------
  logic [NW-1:0] neon_cnt_q, neon_cnt_d;
  logic          neon_q, neon_d;

  always_comb begin
    neon_cnt_d = neon_cnt_q;
    neon_d     = neon_q;
    if (!en) begin
      neon_cnt_d = '0;
      neon_d     = 1'b0;
    end else if (neon_cnt_q == NEON_LAST) begin
      neon_cnt_d = '0;
      neon_d     = ~neon_q;
    end else begin
      neon_cnt_d = neon_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neon_cnt_q <= '0;
      neon_q     <= 1'b0;
    end else begin
      neon_cnt_q <= neon_cnt_d;
      neon_q     <= neon_d;
    end
  end

  assign neon_pwm = neon_q;

endmodule

// File: tb/tb_nixie_fade_driver.sv
// Testbench for nixie_fade_driver. Directed scenarios followed by random
// stimulus, every cycle compared against an arithmetic reference model:
//   pwm_cnt after edge e   = e mod P
//   fade_pos after edge e  = min(P, (wraps since latch edge k) / FADE_DIV)
//                            with wraps = floor(e/P) - floor(k/P)
//   neon after edge e      = floor(r / NEON_DIV) mod 2, r = run of enabled edges
module tb_nixie_fade_driver;
  localparam int NT = 2, SPT = 4, PB = 3, FD = 1, ND = 2;
  localparam int W = NT * SPT;
  localparam int P = 1 << PB;
`ifdef NIXIE_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sdata = 1'b0, shift_en = 1'b0, latch = 1'b0, en = 1'b1;
  logic [PB-1:0] brightness = '0;
  logic [W-1:0]  out;
  logic          neon_pwm, fade_busy;

  int n_cmp = 0, n_err = 0;

  // reference model state (values after the most recent edge)
  int           m_e, m_k, m_run;
  logic [W-1:0] m_sr, m_cur, m_prev;

  always #5 clk = ~clk;

  nixie_fade_driver #(
    .NUM_TUBES(NT), .SEGS_PER_TUBE(SPT), .PWM_BITS(PB),
    .FADE_DIV(FD), .NEON_DIV(ND)
  ) dut (
    .clk(clk), .rst(rst), .sdata(sdata), .shift_en(shift_en), .latch(latch),
    .en(en), .brightness(brightness), .out(out), .neon_pwm(neon_pwm),
    .fade_busy(fade_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int fade_pos(input int e);
    int wraps;
    if (m_k < 0 || !FADE_ON) return P;
    wraps = e / P - m_k / P;
    return (wraps / FD >= P) ? P : wraps / FD;
  endfunction

  task automatic model_reset();
    m_e = 0; m_k = -1; m_run = 0;
    m_sr = '0; m_cur = '0; m_prev = '0;
  endtask

  // Drive one cycle of inputs, predict, clock, update model, compare.
  task automatic step(input logic sd, input logic se, input logic la);
    logic [W-1:0] exp_out;
    int pwm, fp, fp_after;
    logic en_s;
    sdata = sd; shift_en = se; latch = la;
    en_s = en;
    pwm  = m_e % P;
    fp   = fade_pos(m_e);
    if (en_s && pwm < int'(brightness)) exp_out = (pwm < fp) ? m_cur : m_prev;
    else                                exp_out = '0;
    @(posedge clk); #1;
    m_e++;
    if (la) begin m_prev = m_cur; m_cur = m_sr; m_k = m_e; end
    if (se) m_sr = {m_sr[W-2:0], sd};
    m_run = en_s ? m_run + 1 : 0;
    fp_after = fade_pos(m_e);
    chk("out", 32'(out), 32'(exp_out));
    chk("fade_busy", 32'(fade_busy), 32'(FADE_ON && fp_after < P));
    chk("neon_pwm", 32'(neon_pwm), 32'((m_run / ND) % 2));
    shift_en = 1'b0; latch = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_word(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_neon", 32'(neon_pwm), 0);
    chk("rst_busy", 32'(fade_busy), 0);
    #12 rst = 1'b0;

    // basic pattern at full brightness
    brightness = 3'd7;
    shift_word(8'hA5);
    step(1'b0, 1'b0, 1'b1);
    run(80);
    // brightness extremes and mid duty
    brightness = 3'd0; run(16);
    brightness = 3'd4; run(16);

    // crossfade 0x0F -> 0xF0
    brightness = 3'd7;
    shift_word(8'h0F); step(1'b0, 1'b0, 1'b1); run(70);
    shift_word(8'hF0); step(1'b0, 1'b0, 1'b1); run(80);

    // latch and shift in the same cycle, then relatch mid-fade
    shift_word(8'h3C);
    step(1'b1, 1'b1, 1'b1);
    run(20);
    step(1'b0, 1'b0, 1'b1);
    run(70);

    // enable gating of out and neon
    run(12);
    en = 1'b0; run(6);
    en = 1'b1; run(12);

    // asynchronous reset mid-fade
    shift_word(8'hFF); step(1'b0, 1'b0, 1'b1); run(21);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_neon", 32'(neon_pwm), 0);
    chk("async_rst_busy", 32'(fade_busy), 0);
    @(posedge clk); #1;
    chk("rst_hold_out", 32'(out), 0);
    rst = 1'b0;
    model_reset();
    run(20);

    // random stimulus
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) brightness = PB'($urandom_range(0, P - 1));
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    en = 1'b1;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nixie_fade_driver.md
# nixie_fade_driver

Parametrised nixie-tube cathode driver. It receives digit/segment patterns over a synchronous serial shift interface and double-buffers them behind a latch strobe. It applies global PWM brightness and, optionally, a timed crossfade from the previous pattern to the new one. It also generates the neon-separator drive. The block sits between the MCU serial link and the high-voltage cathode driver array.

## Interface
- NUM_TUBES, 6, number of tubes
- SEGS_PER_TUBE, 12, cathode lines per tube; W = NUM_TUBES*SEGS_PER_TUBE
- PWM_BITS, 8, brightness/PWM counter width
- FADE_DIV, 1, PWM periods per fade step (≥1)
- NEON_DIV, 4096, clk cycles per neon_pwm half-period (≥1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- sdata  in  1  serial pattern bit
- shift_en  in  1  sample sdata into shift register this cycle
- latch  in  1  single-cycle strobe: transfer shift register to display
- en  in  1  output enable
- brightness  in  PWM_BITS  global duty
- out  out  W  cathode drive, registered
- neon_pwm  out  1  neon separator square wave
- fade_busy  out  1  crossfade in progress

## Operation
- Shift register SR[W-1:0]: on shift_en, SR <= {SR[W-2:0], sdata}. The first bit sent ends in the MSB after W shifts.
- Display registers cur[W-1:0] and prev[W-1:0].
- On latch: prev <= cur, cur <= SR, fade_pos <= 0, state <= FADING.
- pwm_cnt: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 → 0.
- Brightness gate: on = (pwm_cnt < brightness).
  - brightness=0 gives always off.
  - Maximum brightness gives (2^PWM_BITS-1)/2^PWM_BITS duty.
- Fade state machine:
  - IDLE: fade_pos = 2^PWM_BITS (PWM_BITS+1 bits). latch → FADING.
  - FADING: div_cnt counts pwm_cnt wraps modulo FADE_DIV. On the wrap with div_cnt==FADE_DIV-1, fade_pos++. When fade_pos reaches 2^PWM_BITS → IDLE.
  - fade_busy = (state==FADING).
- Pattern select: pat = (pwm_cnt < fade_pos) ? cur : prev.
- Output: out <= (en && on) ? pat : 0.
- neon_pwm: counter 0..NEON_DIV-1, toggles on terminal count. It is forced to 0 and the counter is held at 0 while en=0.
- Boundary rules:
  - latch and shift_en in the same cycle: cur takes SR before this cycle's shift; the shift still occurs.
  - latch during FADING: prev <= cur (the new target, not the blend), fade restarts from 0, div_cnt <= 0.
  - brightness change takes effect on the next compare; no resync.
  - en=0 does not stop pwm_cnt, the fade or SR.

## Timing
- Reset (async, immediate) values:
  - Outputs: out=0, neon_pwm=0, fade_busy=0.
  - Internal: SR=cur=prev=0, pwm_cnt=0, div_cnt=0, neon counter=0, state IDLE, fade_pos=2^PWM_BITS.
- Latch at edge k updates cur/prev/state at k. out reflects the new state from edge k+1.
- out has one-cycle latency from pwm_cnt, en and brightness.
- Fade duration = 2^PWM_BITS × FADE_DIV × 2^PWM_BITS clk cycles, ±1 PWM period depending on latch phase. fade_busy rises at edge k.
- neon_pwm period = 2×NEON_DIV clk cycles.

## Configuration
- NIXIE_FADE_EN defined: crossfade as above.
- NIXIE_FADE_EN undefined:
  - No prev, fade_pos, div_cnt or state logic.
  - latch loads cur only and pat = cur.
  - fade_busy tied 0.
  - All other behaviour is identical.

## Test plan
All scenarios use NUM_TUBES=2, SEGS_PER_TUBE=4, PWM_BITS=3, FADE_DIV=1, NEON_DIV=2, en=1 unless stated.
- Shift 0xA5 MSB-first, latch, brightness=7 → from latch+1, out=0xA5 when the registered pwm_cnt was 0..6 and 0x00 when it was 7.
- brightness=0 → out=0x00 continuously; brightness=4 → 0xA5 for 4 of every 8 cycles.
- Fade (macro on): cur=0x0F, load 0xF0, latch, brightness=7:
  - fade_busy is high for 64 cycles (±8).
  - In step s, out=0xF0 for pwm_cnt<s and 0x0F for pwm_cnt≥s.
  - After the fade, 0xF0 only.
  - With the macro off, 0xF0 appears at latch+1 and fade_busy stays 0.
- shift_en and latch in the same cycle, SR=0x3C, sdata=1 → cur=0x3C, SR=0x79. A second latch mid-fade makes prev=0x3C and fade_pos restart at 0.
- Assert rst mid-fade with out nonzero → out, neon_pwm and fade_busy drop to 0 without a clock edge. After release, out stays 0 until a new latch.
- en=1 → neon_pwm period is 4 cycles. en=0 → out=0 from the next edge and neon_pwm=0. Re-enabling restarts neon_pwm from counter 0.
